// File: rtl/dff_write_arbiter.sv
// Four-requester round-robin arbiter writing into one shared register.
// Define DFF_ARB_LOCK_EN to add the per-requester burst-lock port and LOCKED state.
module dff_write_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   d_in,
`ifdef DFF_ARB_LOCK_EN
  input  logic [3:0]           lock,
`endif
  output logic [3:0]           gnt,
  output logic [WIDTH-1:0]     q,
  output logic                 q_valid,
  output logic [1:0]           q_src,
  output logic [15:0]          wr_cnt
);

  typedef enum logic [1:0] {StIdle, StGrant, StLocked} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic [1:0]       q_src_q, q_src_d;
  logic [15:0]      wr_cnt_q, wr_cnt_d;

  logic [3:0]       eligible;
  logic             found;
  logic [1:0]       win;
  logic [1:0]       idx;

  always_comb begin
    // A requester granted this cycle sits out the next edge.
    eligible = req & ~gnt_q;
    found    = 1'b0;
    win      = 2'd0;
    idx      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = 4'b0000;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    q_src_d   = q_src_q;
    wr_cnt_d  = wr_cnt_q;

    unique case (state_q)
      StIdle, StGrant: begin
        if (found) begin
          q_d       = d_in[win*WIDTH +: WIDTH];
          gnt_d     = 4'b0001 << win;
          q_src_d   = win;
          q_valid_d = 1'b1;
          wr_cnt_d  = wr_cnt_q + 16'd1;
          ptr_d     = win + 2'd1;
          state_d   = StGrant;
`ifdef DFF_ARB_LOCK_EN
          if (lock[win]) state_d = StLocked;
`endif
        end else begin
          state_d = StIdle;
        end
      end
`ifdef DFF_ARB_LOCK_EN
      // The lock owner is the last writer; ptr already points past it.
      StLocked: begin
        if (req[q_src_q] && lock[q_src_q]) begin
          q_d      = d_in[q_src_q*WIDTH +: WIDTH];
          gnt_d    = gnt_q;
          wr_cnt_d = wr_cnt_q + 16'd1;
        end else begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= 2'd0;
      gnt_q     <= 4'b0000;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      q_src_q   <= 2'd0;
      wr_cnt_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      q_src_q   <= q_src_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign q_src   = q_src_q;
  assign wr_cnt  = wr_cnt_q;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Randomised and directed bench for dff_write_arbiter against a round-robin reference model.
module tb_dff_write_arbiter;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3:0]     req = 4'b0000;
  logic [4*W-1:0] din = '0;
`ifdef DFF_ARB_LOCK_EN
  logic [3:0]     lock = 4'b0000;
`endif
  logic [3:0]     gnt;
  logic [W-1:0]   q;
  logic           q_valid;
  logic [1:0]     q_src;
  logic [15:0]    wr_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_ptr = 0;
  logic [3:0]  m_gnt = 4'b0000;
  logic [W-1:0] m_q  = '0;
  logic        m_valid = 1'b0;
  logic [1:0]  m_src = 2'd0;
  logic [15:0] m_cnt = 16'd0;

  dff_write_arbiter #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .d_in   (din),
`ifdef DFF_ARB_LOCK_EN
    .lock   (lock),
`endif
    .gnt    (gnt),
    .q      (q),
    .q_valid(q_valid),
    .q_src  (q_src),
    .wr_cnt (wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    int win;
    win = -1;
    if (rst) begin
      m_ptr = 0; m_gnt = 4'b0000; m_q = '0; m_valid = 1'b0; m_src = 2'd0; m_cnt = 16'd0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (win < 0 && req[i] && !m_gnt[i]) win = i;
      end
      if (win >= 0) begin
        m_q     = din[win*W +: W];
        m_gnt   = 4'b0000;
        m_gnt[win] = 1'b1;
        m_src   = 2'(win);
        m_valid = 1'b1;
        m_cnt   = m_cnt + 16'd1;
        m_ptr   = (win + 1) % 4;
      end else begin
        m_gnt = 4'b0000;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    din = $urandom;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (q !== '0 || q_valid !== 1'b0 || gnt !== 4'b0000 || wr_cnt !== 16'd0) begin
        bad++;
        $display("FAIL reset cyc=%0d got q=%h v=%b gnt=%b cnt=%0d want all zero",
                 c, q, q_valid, gnt, wr_cnt);
      end
    end
    rst = 1'b0;
    req = 4'b0000;
  endtask

  task automatic test_single_write();
    do_reset();
    req = 4'b0100;
    din = 32'h11A52233;
    tick();
    total++;
    if (gnt !== 4'b0100 || q !== 8'hA5 || q_src !== 2'd2 || wr_cnt !== 16'd1 || q_valid !== 1'b1)
    begin
      bad++;
      $display("FAIL single_write got gnt=%b q=%h src=%0d cnt=%0d v=%b want 0100 a5 2 1 1",
               gnt, q, q_src, wr_cnt, q_valid);
    end
    // ptr should now be 3, so requester 3 beats 0 and 1
    req = 4'b1011;
    tick();
    total++;
    if (gnt !== 4'b1000 || q_src !== 2'd3) begin
      bad++;
      $display("FAIL ptr_after_single got gnt=%b src=%0d want 1000 3", gnt, q_src);
    end
    req = 4'b0000;
  endtask

  task automatic test_rotate();
    logic [3:0] exp;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      din = $urandom;
      tick();
      exp = 4'b0001 << (c % 4);
      total++;
      if (gnt !== exp) begin
        bad++;
        $display("FAIL rotate cyc=%0d got gnt=%b want %b", c, gnt, exp);
      end
    end
    total++;
    if (wr_cnt !== 16'd8) begin
      bad++;
      $display("FAIL rotate_cnt got %0d want 8", wr_cnt);
    end
    req = 4'b0000;
  endtask

  task automatic test_persistent_single();
    logic [3:0]   exp_g;
    logic [W-1:0] exp_q;
    do_reset();
    req   = 4'b0001;
    exp_q = '0;
    for (int c = 0; c < 6; c++) begin
      din = $urandom;
      if (c % 2 == 0) exp_q = din[W-1:0];
      exp_g = (c % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
      total++;
      if (gnt !== exp_g || q !== exp_q) begin
        bad++;
        $display("FAIL persistent cyc=%0d got gnt=%b q=%h want %b %h", c, gnt, q, exp_g, exp_q);
      end
    end
    total++;
    if (wr_cnt !== 16'd3) begin
      bad++;
      $display("FAIL persistent_cnt got %0d want 3", wr_cnt);
    end
    req = 4'b0000;
  endtask

  task automatic test_random();
    logic [3:0] sampled;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      req = 4'($urandom);
      din = $urandom;
      sampled = req;
      tick();
      total++;
      if (gnt !== m_gnt || q !== m_q || q_valid !== m_valid || q_src !== m_src ||
          wr_cnt !== m_cnt) begin
        bad++;
        $display("FAIL random cyc=%0d got g=%b q=%h v=%b s=%0d n=%0d want g=%b q=%h v=%b s=%0d n=%0d",
                 c, gnt, q, q_valid, q_src, wr_cnt, m_gnt, m_q, m_valid, m_src, m_cnt);
      end
      total++;
      if ($countones(gnt) > 1 || (gnt & ~sampled) !== 4'b0000) begin
        bad++;
        $display("FAIL random_onehot cyc=%0d got gnt=%b req=%b want onehot subset", c, gnt, sampled);
      end
    end
    rst = 1'b0;
    req = 4'b0000;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 65535; c++) begin
      din = $urandom;
      tick();
    end
    total++;
    if (wr_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_preload got %h want ffff", wr_cnt);
    end
    din = $urandom;
    tick();
    total++;
    if (wr_cnt !== 16'h0000 || q !== m_q || gnt !== 4'b1000) begin
      bad++;
      $display("FAIL wrap got cnt=%h q=%h gnt=%b want 0000 %h 1000", wr_cnt, q, gnt, m_q);
    end
    req = 4'b0000;
  endtask

`ifdef DFF_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    req  = 4'b0011;
    lock = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      din = $urandom;
      tick();
      total++;
      if (gnt !== 4'b0001 || q !== din[W-1:0]) begin
        bad++;
        $display("FAIL lock_hold cyc=%0d got gnt=%b q=%h want 0001 %h", c, gnt, q, din[W-1:0]);
      end
    end
    lock = 4'b0000;
    tick();
    total++;
    if (gnt !== 4'b0000 || wr_cnt !== 16'd4) begin
      bad++;
      $display("FAIL lock_exit got gnt=%b cnt=%0d want 0000 4", gnt, wr_cnt);
    end
    tick();
    total++;
    if (gnt !== 4'b0010 || q_src !== 2'd1) begin
      bad++;
      $display("FAIL lock_next got gnt=%b src=%0d want 0010 1", gnt, q_src);
    end
    req = 4'b0000;
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_rotate();
    test_persistent_single();
    test_random();
    test_wrap();
`ifdef DFF_ARB_LOCK_EN
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dff_write_arbiter.md
DFF_WRITE_ARBITER -- requirements
Module: dff_write_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, data width of shared register and of each requester data input.
REQ-002 Port: clk  input  1  rising-edge clock, sole clock of block.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req  input  4  per-requester write request, bit i = requester i.
REQ-005 Port: d_in  input  4*WIDTH  packed requester data; slice [i*WIDTH +: WIDTH] = requester i.
REQ-006 Port: gnt  output  4  one-hot grant, registered.
REQ-007 Port: q  output  WIDTH  shared register contents.
REQ-008 Port: q_valid  output  1  high once q has been written since reset.
REQ-009 Port: q_src  output  2  index of requester that last wrote q.
REQ-010 Port: wr_cnt  output  16  count of completed writes.

Function
REQ-011 Fixed 4 requesters; round-robin pointer ptr (2 bits) names highest-priority requester.
REQ-012 Eligible(i) = req[i] AND NOT gnt[i]; a requester granted in the current cycle cannot win at the next edge.
REQ-013 At each edge with any eligible requester, winner w = first eligible index scanning ptr, ptr+1, ... mod 4.
REQ-014 Same edge: q <= d_in slice w, gnt <= one-hot(w), q_src <= w, q_valid <= 1, wr_cnt <= wr_cnt+1, ptr <= (w+1) mod 4.
REQ-015 Latency: req sampled at edge N -> gnt high and new q visible during cycle N+1 (one cycle).
REQ-016 No eligible requester: gnt <= 0; q, q_src, ptr, wr_cnt unchanged.
REQ-017 gnt is a one-cycle pulse per write (outside LOCKED); requester deasserts req or keeps it for a further write, re-granted no earlier than 2 cycles later.
REQ-018 Single persistent requester: granted every other cycle; all four persistent: grants rotate 0,1,2,3 fairly after ptr.
REQ-019 gnt never has more than one bit set; gnt bit never set for a requester whose req was low at the granting edge.
REQ-020 wr_cnt wraps 16'hFFFF -> 16'h0000 without side effect.
REQ-021 States: IDLE (gnt=0), GRANT (one-hot gnt pulse), LOCKED (only with REQ-029); IDLE->GRANT on eligible request, GRANT->GRANT on another eligible request, GRANT->IDLE otherwise.
REQ-022 Data in d_in slices of non-winning requesters has no effect.

Reset
REQ-023 rst high at an edge: q=0, q_valid=0, q_src=0, gnt=0, wr_cnt=0, ptr=0, state IDLE.
REQ-024 Reset overrides all requests in the same cycle; no write occurs at a reset edge.
REQ-025 Reset mid-grant or mid-lock drops grant/lock immediately; first post-reset grant uses ptr=0.

Configuration
REQ-026 Macro DFF_ARB_LOCK_EN selects burst-lock feature.
REQ-027 Without macro: no lock port, no LOCKED state, behaviour per REQ-011..022.
REQ-028 With macro: extra port lock  input  4, per-requester bus lock.
REQ-029 With macro: if winner w has lock[w] high at granting edge, state -> LOCKED; gnt[w] held high; every edge with req[w] AND lock[w] writes d_in slice w to q and increments wr_cnt; no other requester granted.
REQ-030 With macro: LOCKED exits to IDLE at first edge with req[w] or lock[w] low (no write at that edge); ptr stays (w+1) mod 4.

Verification
REQ-031 rst=1 two cycles with req=4'b1111 -> q=0, q_valid=0, gnt=0, wr_cnt=0 throughout.
REQ-032 WIDTH=8, req=4'b0100, slice2=8'hA5, one edge -> next cycle gnt=4'b0100, q=8'hA5, q_src=2, wr_cnt=1, ptr=3.
REQ-033 req=4'b1111 held 8 cycles after reset -> gnt sequence 0001,0010,0100,1000,0001,... one per cycle, wr_cnt=8.
REQ-034 req=4'b0001 held -> gnt alternates 0001,0000; q updates every other cycle.
REQ-035 Preload wr_cnt to 16'hFFFF via 65535 writes, one more write -> wr_cnt=0, q updated.
REQ-036 With DFF_ARB_LOCK_EN: req=4'b0011, lock=4'b0001 for 4 cycles -> gnt=0001 for 4 cycles, 4 writes from slice0; lock drops -> next grant to requester 1.
